// File: rtl/div_4bit.sv
// Sequential restoring divider: one quotient bit per clock, trial subtraction on a
// ripple-borrow chain of full_subtractor cells, start/busy/done handshake.

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);
   assign diff = a ^ b ^ bin;
   assign bout = (~a & b) | (~a & bin) | (b & bin);
endmodule

// Handshake: start is sampled only in IDLE; busy is high from the accepting edge
// until the edge after the one-cycle done pulse; results hold until the next done.
module div_4bit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] Dividend,
   input  logic [WIDTH-1:0] Divisor,
   output logic [WIDTH-1:0] Quotient,
   output logic [WIDTH-1:0] Remainder,
   output logic             busy,
   output logic             done,
   output logic             DivZero,
   output logic [1:0]       dbg_state,
   output logic [WIDTH:0]   dbg_rem
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [WIDTH:0]   r_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] d_q;
   logic [CW-1:0]    cnt_q;
   logic             dz_q;

   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   sub_b;
   logic [WIDTH:0]   diff;
   logic [WIDTH+1:0] borrow;
   logic             qbit;

   assign trial     = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
   assign sub_b     = {1'b0, d_q};
   assign borrow[0] = 1'b0;

   for (genvar i = 0; i <= WIDTH; i++) begin : g_chain
      full_subtractor u_fs (
         .a    (trial[i]),
         .b    (sub_b[i]),
         .bin  (borrow[i]),
         .diff (diff[i]),
         .bout (borrow[i+1])
      );
   end

   // No final borrow means the trial fits: keep the difference and emit a 1.
   assign qbit = ~borrow[WIDTH+1];

   assign busy      = (state != IDLE);
   assign dbg_state = state;
   assign dbg_rem   = r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: if (start) state_nx = CALC;
         // A zero divisor spends one cycle here without stepping the datapath.
         CALC: if (dz_q || (cnt_q == CW'(WIDTH - 1))) state_nx = DONE;
         DONE: if (done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q       <= '0;
         q_q       <= '0;
         d_q       <= '0;
         cnt_q     <= '0;
         dz_q      <= 1'b0;
         Quotient  <= '0;
         Remainder <= '0;
         DivZero   <= 1'b0;
         done      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  q_q   <= Dividend;
                  d_q   <= Divisor;
                  r_q   <= '0;
                  cnt_q <= '0;
                  dz_q  <= (Divisor == '0);
               end
            end
            CALC: begin
               if (!dz_q) begin
                  r_q   <= qbit ? diff : trial;
                  q_q   <= {q_q[WIDTH-2:0], qbit};
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DONE: begin
               // First DONE cycle loads results; second one retires the pulse.
               if (!done) begin
                  done      <= 1'b1;
                  Quotient  <= dz_q ? '1 : q_q;
                  Remainder <= dz_q ? q_q : r_q[WIDTH-1:0];
                  DivZero   <= dz_q;
               end else begin
                  done <= 1'b0;
               end
            end
            default: done <= 1'b0;
         endcase
      end
   end
endmodule

// File: tb/tb_div_4bit.sv
// Directed and randomized checks of div_4bit against an arithmetic reference
// (a/b, a%b, all-ones quotient on zero divisor) plus handshake timing.

module tb_div_4bit;
   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] Dividend;
   logic [3:0] Divisor;
   logic [3:0] Quotient;
   logic [3:0] Remainder;
   logic       busy;
   logic       done;
   logic       DivZero;
   logic [1:0] dbg_state;
   logic [4:0] dbg_rem;

   int vectors;
   int miscompares;

   logic [3:0] prev_q;
   logic [3:0] prev_r;
   logic       prev_dz;

   div_4bit #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .Dividend  (Dividend),
      .Divisor   (Divisor),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .busy      (busy),
      .done      (done),
      .DivZero   (DivZero),
      .dbg_state (dbg_state),
      .dbg_rem   (dbg_rem)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Runs one division; hold keeps start high after acceptance (back-to-back issue).
   task automatic do_div(input logic [3:0] a, input logic [3:0] b, input bit hold);
      int         lat;
      int         acc_edge;
      bit         got;
      logic [3:0] eq;
      logic [3:0] er;
      logic       edz;
      int         elat;
      edz  = (b == 4'd0);
      eq   = edz ? 4'hF : 4'(int'(a) / int'(b));
      er   = edz ? a : 4'(int'(a) % int'(b));
      elat = edz ? 2 : 5;
      Dividend = a;
      Divisor  = b;
      start    = 1'b1;
      got      = 1'b0;
      acc_edge = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (busy) begin
            got      = 1'b1;
            acc_edge = k;
            break;
         end
      end
      if (!got) begin
         chk("accept_timeout", 0, 1);
         start = 1'b0;
         return;
      end
      chk("accept_edge", acc_edge, 0);
      if (!hold) start = 1'b0;
      lat = 0;
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         lat++;
         if (done) begin
            got = 1'b1;
            break;
         end
         chk("hold_quot", 32'(Quotient), 32'(prev_q));
         chk("hold_rem", 32'(Remainder), 32'(prev_r));
         chk("hold_dz", 32'(DivZero), 32'(prev_dz));
         chk("busy_calc", 32'(busy), 1);
      end
      if (!got) begin
         chk("done_timeout", 0, 1);
         return;
      end
      chk("latency", lat, elat);
      chk("quot", 32'(Quotient), 32'(eq));
      chk("rem", 32'(Remainder), 32'(er));
      chk("divzero", 32'(DivZero), 32'(edz));
      chk("busy_done", 32'(busy), 1);
      @(posedge clk); #1;
      chk("done_pulse", 32'(done), 0);
      chk("busy_drop", 32'(busy), 0);
      prev_q  = eq;
      prev_r  = er;
      prev_dz = edz;
   endtask

   initial begin
      int         dn;
      logic [3:0] rq;
      logic [3:0] rr;
      vectors     = 0;
      miscompares = 0;
      rst_n    = 1'b0;
      start    = 1'b0;
      Dividend = '0;
      Divisor  = '0;
      prev_q   = '0;
      prev_r   = '0;
      prev_dz  = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_quot", 32'(Quotient), 0);
      chk("rst_rem", 32'(Remainder), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_dz", 32'(DivZero), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed divisions
      do_div(4'd13, 4'd3, 1'b0);
      do_div(4'd15, 4'd1, 1'b0);
      do_div(4'd3,  4'd7, 1'b0);
      do_div(4'd5,  4'd0, 1'b0);
      do_div(4'd9,  4'd2, 1'b0);

      // A start pulse during CALC is dropped
      Dividend = 4'd14;
      Divisor  = 4'd3;
      start    = 1'b1;
      @(posedge clk); #1;
      chk("ign_accept", 32'(busy), 1);
      start = 1'b0;
      @(posedge clk); #1;
      Dividend = 4'd6;
      Divisor  = 4'd2;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dn = 0;
      rq = '0;
      rr = '0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done) begin
            dn++;
            rq = Quotient;
            rr = Remainder;
         end
      end
      chk("ign_done_count", dn, 1);
      chk("ign_quot", 32'(rq), 32'(14 / 3));
      chk("ign_rem", 32'(rr), 32'(14 % 3));
      chk("ign_idle", 32'(busy), 0);
      prev_q  = 4'd4;
      prev_r  = 4'd2;
      prev_dz = 1'b0;

      // Reset in the middle of CALC
      Dividend = 4'd12;
      Divisor  = 4'd5;
      start    = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_quot", 32'(Quotient), 0);
      chk("mid_rst_rem", 32'(Remainder), 0);
      chk("mid_rst_busy", 32'(busy), 0);
      chk("mid_rst_done", 32'(done), 0);
      chk("mid_rst_dz", 32'(DivZero), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      dn = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (done) dn++;
      end
      chk("mid_rst_no_done", dn, 0);
      prev_q  = '0;
      prev_r  = '0;
      prev_dz = 1'b0;
      do_div(4'd12, 4'd5, 1'b0);

      // Exhaustive back-to-back with start held high
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            do_div(4'(a), 4'(b), 1'b1);
         end
      end
      start = 1'b0;

      // Randomized operands with randomized start style
      for (int n = 0; n < 40; n++) begin
         do_div(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      start = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
